fp_unpack_stream: RTL

FP_UNPACK_STREAM -- requirements
Module: fp_unpack_stream

---
 rtl/fpnew_pkg_snax.sv | 49 ++++
 rtl/fp_unpack_stream_if.sv | 34 +++
 rtl/lzc_snax.sv | 32 +++
 rtl/fp_unpack_stream.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg_snax.sv
// Floating-point format helpers shared by the FP datapath blocks.
// Provides the format enum, per-format field widths and bias, and the
// packed classification vector emitted by the unpacker.
package fpnew_pkg_snax;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    // Bit 4 down to bit 0 of the class vector.
    typedef struct packed {
        logic is_signalling;
        logic is_nan;
        logic is_inf;
        logic is_subnormal;
        logic is_zero;
    } fp_class_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:      return 11;
            FP16, FP8: return 5;
            default:   return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned bias(fp_format_e fmt);
        return (32'd1 << (exp_bits(fmt) - 1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

// File: rtl/fp_unpack_stream_if.sv
// Valid/ready stream bundle for the FP unpacker.
//   in_*  : packed operand stream into the unpacker
//   out_* : unpacked sign / exponent / significand / class stream out
// slave  : the unpacker side; master : the producer/consumer side.
interface fp_unpack_stream_if #(
    parameter fpnew_pkg_snax::fp_format_e FpFormat = fpnew_pkg_snax::fp_format_e'(0),
    parameter int unsigned WIDTH = fpnew_pkg_snax::fp_width(FpFormat)
);
    import fpnew_pkg_snax::*;

    localparam int unsigned EXP_BITS = exp_bits(FpFormat);
    localparam int unsigned MAN_BITS = man_bits(FpFormat);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [WIDTH-1:0]      in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_sign_o;
    logic [EXP_BITS+1:0]   out_exp_o;
    logic [MAN_BITS:0]     out_sig_o;
    fp_class_t             out_class_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sign_o, out_exp_o, out_sig_o, out_class_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sign_o, out_exp_o, out_sig_o, out_class_o
    );

endinterface

// File: rtl/lzc_snax.sv
// Leading/trailing zero counter.
//   in_i    : vector to scan
//   cnt_o   : MODE=1 leading zeros, MODE=0 trailing zeros (0 when empty)
//   empty_o : in_i is all zeros
module lzc_snax #(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Later loop iterations override earlier ones, so the scan order picks
    // the set bit nearest the counted end.
    always_comb begin
        cnt_o = '0;
        if (MODE) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/fp_unpack_stream.sv
// Two-stage streaming FP operand unpacker.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : in_* packed operand stream, out_* unpacked stream with
//                  sign, unbiased normalized exponent, significand with
//                  explicit integer bit, and class vector.
// S1 classifies and counts leading zeros; S2 normalizes.
module fp_unpack_stream
    import fpnew_pkg_snax::*;
#(
    parameter fp_format_e  FpFormat = fp_format_e'(0),
    parameter int unsigned WIDTH    = fp_width(FpFormat)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fp_unpack_stream_if.slave bus
);

    localparam int unsigned EXP_BITS = exp_bits(FpFormat);
    localparam int unsigned MAN_BITS = man_bits(FpFormat);
    localparam int unsigned EW       = EXP_BITS + 2;
    localparam int unsigned LZ_BITS  = (MAN_BITS + 1 > 1) ? $clog2(MAN_BITS + 1) : 1;
    localparam logic signed [EW-1:0] BIAS_S = EW'(bias(FpFormat));

    logic [WIDTH-1:0]    in_data;
    logic                in_sign;
    logic [EXP_BITS-1:0] in_exp;
    logic [MAN_BITS-1:0] in_man;
    logic [LZ_BITS-1:0]  in_lz;
    logic                man_zero;
    logic                exp_zero;
    logic                exp_ones;
    fp_class_t           in_class;

    assign in_data  = bus.in_data_i;
    assign in_sign  = in_data[WIDTH-1];
    assign in_exp   = in_data[MAN_BITS +: EXP_BITS];
    assign in_man   = in_data[MAN_BITS-1:0];
    assign exp_zero = (in_exp == '0);
    assign exp_ones = &in_exp;

    // The counter's empty flag doubles as the mantissa-is-zero detect.
    lzc_snax #(
        .WIDTH (MAN_BITS + 1),
        .MODE  (1'b1)
    ) u_lzc (
        .in_i    ({1'b0, in_man}),
        .cnt_o   (in_lz),
        .empty_o (man_zero)
    );

    always_comb begin
        in_class               = '0;
        in_class.is_zero       = exp_zero & man_zero;
        in_class.is_subnormal  = exp_zero & ~man_zero;
        in_class.is_inf        = exp_ones & man_zero;
        in_class.is_nan        = exp_ones & ~man_zero;
        in_class.is_signalling = exp_ones & ~man_zero & ~in_man[MAN_BITS-1];
    end

    // Stage handshake: a stage loads when empty or drained this cycle.
    logic s1_valid, s2_valid, s1_ready, s2_ready;

    assign s2_ready       = !s2_valid || bus.out_ready_i;
    assign s1_ready       = !s1_valid || s2_ready;
    assign bus.in_ready_o = s1_ready;

    logic                s1_sign;
    fp_class_t           s1_class;
    logic [EXP_BITS-1:0] s1_exp;
    logic [MAN_BITS-1:0] s1_man;
    logic [LZ_BITS-1:0]  s1_lz;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_class <= '0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_lz    <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_sign  <= in_sign;
                s1_class <= in_class;
                s1_exp   <= in_exp;
                s1_man   <= in_man;
                s1_lz    <= in_lz;
            end
        end
    end

    // Inf/NaN share the normal exponent path: the raw field is all ones.
    logic signed [EW-1:0] norm_exp;
    logic [MAN_BITS:0]    norm_sig;

    always_comb begin
        norm_exp = signed'(EW'(s1_exp)) - BIAS_S;
        norm_sig = {1'b1, s1_man};
        if (s1_class.is_zero) begin
            norm_exp = '0;
            norm_sig = '0;
        end else if (s1_class.is_subnormal) begin
            norm_exp = signed'(EW'(1)) - BIAS_S - signed'(EW'(s1_lz));
            norm_sig = {1'b0, s1_man} << s1_lz;
        end else if (s1_class.is_inf || s1_class.is_nan) begin
            norm_sig = {1'b0, s1_man};
        end
    end

    logic              s2_sign;
    fp_class_t         s2_class;
    logic [EW-1:0]     s2_exp;
    logic [MAN_BITS:0] s2_sig;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_class <= '0;
            s2_exp   <= '0;
            s2_sig   <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign  <= s1_sign;
                s2_class <= s1_class;
                s2_exp   <= norm_exp;
                s2_sig   <= norm_sig;
            end
        end
    end

    assign bus.out_valid_o = s2_valid;
    assign bus.out_sign_o  = s2_sign;
    assign bus.out_exp_o   = s2_exp;
    assign bus.out_sig_o   = s2_sig;
    assign bus.out_class_o = s2_class;

endmodule
